// File: rtl/bp_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
// Entry fields are sized for the widest supported configuration.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  localparam int BP_ADDR_MAX = 64;
  localparam int BP_CTR_MAX  = 16;

  function automatic int ctr_weak_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  function automatic int ctr_weak_nt(input int ctr_w);
    return ctr_weak_t(ctr_w) - 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [BP_ADDR_MAX-1:0] tag;
    logic [BP_ADDR_MAX-1:0] target;
    logic [BP_CTR_MAX-1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX update and statistics bundle of the predictor.
// master = core side, slave = predictor side.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic              ready;
  logic [ADDR_W-1:0] pc_if;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output pc_if, upd_valid, upd_pc,
    output upd_taken, upd_target,
    output ex_pred_taken, ex_pred_target,
    input  ready, pred_hit, pred_taken,
    input  pred_target, mispredict,
    input  redirect_pc, stat_branches,
    input  stat_mispredicts
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc,
    input  upd_taken, upd_target,
    input  ex_pred_taken, ex_pred_target,
    output ready, pred_hit, pred_taken,
    output pred_target, mispredict,
    output redirect_pc, stat_branches,
    output stat_mispredicts
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Saturating up/down next-value function for direction counters.
module bp_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, EX-stage
// mispredict detection and branch statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input logic                Clk,
  input logic                Reset,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_WT =
    CTR_W'(ctr_weak_t(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT =
    CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  bp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic              ready;
  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  btb_entry_t        look_e, upd_e;
  logic              lk_hit, up_hit;
  logic              mp;
  logic [CTR_W-1:0]  ctr_sat;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic [CTR_W-1:0]  wr_ctr;

  logic              unused_bits;

  assign ready  = (state_q == RUN);
  assign lk_idx = bp.pc_if[IDX_W+1:2];
  assign lk_tag = bp.pc_if[ADDR_W-1:IDX_W+2];
  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];

  always_comb begin
    look_e        = '0;
    look_e.valid  = valid_q[lk_idx];
    look_e.tag    = BP_ADDR_MAX'(tag_q[lk_idx]);
    look_e.target = BP_ADDR_MAX'(target_q[lk_idx]);
    look_e.ctr    = BP_CTR_MAX'(ctr_q[lk_idx]);
    upd_e         = '0;
    upd_e.valid   = valid_q[up_idx];
    upd_e.tag     = BP_ADDR_MAX'(tag_q[up_idx]);
    upd_e.target  = BP_ADDR_MAX'(target_q[up_idx]);
    upd_e.ctr     = BP_CTR_MAX'(ctr_q[up_idx]);
  end

  // Upper struct bits are zero padding for narrower configs.
  assign unused_bits = ^{look_e, upd_e};

  assign lk_hit = ready & look_e.valid &
    (look_e.tag == BP_ADDR_MAX'(lk_tag));
  assign up_hit = upd_e.valid &
    (upd_e.tag == BP_ADDR_MAX'(up_tag));

  assign bp.ready       = ready;
  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_hit & look_e.ctr[CTR_W-1];
  assign bp.pred_target = bp.pred_taken ?
    look_e.target[ADDR_W-1:0] : bp.pc_if + ADDR_W'(4);

  assign mp = ready & bp.upd_valid &
    ((bp.upd_taken != bp.ex_pred_taken) |
     (bp.upd_taken &
      (bp.upd_target != bp.ex_pred_target)));

  assign bp.mispredict  = mp;
  assign bp.redirect_pc = bp.upd_taken ?
    bp.upd_target : bp.upd_pc + ADDR_W'(4);

  assign bp.stat_branches    = br_cnt_q;
  assign bp.stat_mispredicts = mp_cnt_q;

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_i (upd_e.ctr[CTR_W-1:0]),
    .up_i  (bp.upd_taken),
    .ctr_o (ctr_sat)
  );

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    wr_en      = 1'b0;
    wr_idx     = init_idx_q;
    wr_valid   = 1'b0;
    wr_tag     = tag_q[init_idx_q];
    wr_target  = target_q[init_idx_q];
    wr_ctr     = CTR_WNT;
    if (!Reset) begin
      if (state_q == INIT) begin
        wr_en      = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = RUN;
      end else if (bp.upd_valid) begin
        if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
        if (mp && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
        wr_idx    = up_idx;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = bp.upd_target;
        if (up_hit) begin
          wr_en  = 1'b1;
          wr_ctr = ctr_sat;
          if (!bp.upd_taken)
            wr_target = upd_e.target[ADDR_W-1:0];
        end else if (bp.upd_taken) begin
          wr_en  = 1'b1;
          wr_ctr = CTR_WT;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  // Table arrays carry no reset; the INIT sweep clears them.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, reset sequences and
// randomized traffic against a behavioural BTB model.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32), .STAT_W(32)) bpi ();

  branch_predictor #(
    .ADDR_W(32), .ENTRIES(64), .CTR_W(2), .STAT_W(32)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bp    (bpi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain integer arrays indexed by PC bits.
  bit          m_run = 1'b0;
  int          m_init = 0;
  longint      m_br = 0, m_mp = 0;
  bit          m_v   [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h",
               nm, $time, got, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_run && m_v[i] && (m_tag[i] == (pc >> 8));
  endfunction

  function automatic bit m_mispredict();
    bit t = bpi.upd_taken;
    if (!m_run || !bpi.upd_valid) return 1'b0;
    if (t != bpi.ex_pred_taken) return 1'b1;
    return t && (bpi.upd_target != bpi.ex_pred_target);
  endfunction

  task automatic check_model();
    logic [31:0] pc = bpi.pc_if;
    bit h = m_hit(pc);
    bit t = h && (m_ctr[m_idx(pc)] >= 2);
    logic [31:0] tg = t ? m_tgt[m_idx(pc)] : pc + 32'd4;
    logic [31:0] rd = bpi.upd_taken ? bpi.upd_target
                                    : bpi.upd_pc + 32'd4;
    chk("ready", 64'(bpi.ready), 64'(m_run));
    chk("pred_hit", 64'(bpi.pred_hit), 64'(h));
    chk("pred_taken", 64'(bpi.pred_taken), 64'(t));
    chk("pred_target", 64'(bpi.pred_target), 64'(tg));
    chk("mispredict", 64'(bpi.mispredict),
        64'(m_mispredict()));
    chk("redirect_pc", 64'(bpi.redirect_pc), 64'(rd));
    chk("stat_branches", 64'(bpi.stat_branches), 64'(m_br));
    chk("stat_mispredicts", 64'(bpi.stat_mispredicts),
        64'(m_mp));
  endtask

  task automatic model_edge();
    int i;
    if (rst) begin
      m_run = 1'b0; m_init = 0; m_br = 0; m_mp = 0;
    end else if (!m_run) begin
      m_v[m_init] = 1'b0;
      m_ctr[m_init] = 1;
      m_init++;
      if (m_init == 64) begin
        m_run = 1'b1; m_init = 0;
      end
    end else if (bpi.upd_valid) begin
      i = m_idx(bpi.upd_pc);
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (m_mispredict() && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (m_hit(bpi.upd_pc)) begin
        if (bpi.upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = bpi.upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bpi.upd_taken) begin
        m_v[i] = 1'b1;
        m_tag[i] = bpi.upd_pc >> 8;
        m_tgt[i] = bpi.upd_target;
        m_ctr[i] = 2;
      end
    end
  endtask

  task automatic tick(input bit use_model);
    #1;
    if (use_model) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc,
                         input bit t, input logic [31:0] tg,
                         input bit ept, input logic [31:0] etg);
    bpi.upd_valid      = v;
    bpi.upd_pc         = pc;
    bpi.upd_taken      = t;
    bpi.upd_target     = tg;
    bpi.ex_pred_taken  = ept;
    bpi.ex_pred_target = etg;
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    bit          ept;
    logic [31:0] etg;
    bit          e_hit;
    bit          e_tk;
    logic [31:0] e_tgt;
    bit          e_mp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [15];

  initial begin
    int n;
    vt[0]  = '{32'h00400020, 1, 32'h00400020, 1, 32'h00400008,
               0, 32'h0, 0, 0, 32'h00400024, 1, 32'h00400008};
    vt[1]  = '{32'h00400020, 0, 32'h0, 0, 32'h0,
               0, 32'h0, 1, 1, 32'h00400008, 0, 32'h4};
    vt[2]  = '{32'h00400020, 1, 32'h00400020, 1, 32'h00400008,
               1, 32'h00400008, 1, 1, 32'h00400008, 0,
               32'h00400008};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = '{32'h00400020, 1, 32'h00400020, 0, 32'h00400008,
               1, 32'h00400008, 1, 1, 32'h00400008, 1,
               32'h00400024};
    vt[6]  = vt[5];
    vt[7]  = '{32'h00400020, 0, 32'h0, 0, 32'h0,
               0, 32'h0, 1, 0, 32'h00400024, 0, 32'h4};
    vt[8]  = '{32'h00400020, 1, 32'h00400120, 1, 32'h00400200,
               0, 32'h0, 1, 0, 32'h00400024, 1, 32'h00400200};
    vt[9]  = '{32'h00400020, 0, 32'h0, 0, 32'h0,
               0, 32'h0, 0, 0, 32'h00400024, 0, 32'h4};
    vt[10] = '{32'h00400120, 0, 32'h0, 0, 32'h0,
               0, 32'h0, 1, 1, 32'h00400200, 0, 32'h4};
    vt[11] = '{32'h00400040, 1, 32'h00400040, 1, 32'h00400100,
               0, 32'h0, 0, 0, 32'h00400044, 1, 32'h00400100};
    vt[12] = '{32'h00400040, 0, 32'h0, 0, 32'h0,
               0, 32'h0, 1, 1, 32'h00400100, 0, 32'h4};
    vt[13] = '{32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,
               0, 32'h0, 0, 0, 32'h00000000, 0, 32'h00000000};
    vt[14] = '{32'h00400040, 1, 32'h00400040, 1, 32'h00400100,
               1, 32'h00400104, 1, 1, 32'h00400100, 1,
               32'h00400100};

    // Reset pulse, then the init sweep with ignored updates.
    bpi.pc_if = 32'h00400010;
    set_upd(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    tick(0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      set_upd(i % 5 == 0, 32'h00400020, 1, 32'h00400008,
              0, 32'h0);
      #1;
      chk("init_ready", 64'(bpi.ready), 64'd0);
      chk("init_hit", 64'(bpi.pred_hit), 64'd0);
      chk("init_target", 64'(bpi.pred_target),
          64'h00400014);
      chk("init_mispredict", 64'(bpi.mispredict), 64'd0);
      tick(0);
    end
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    chk("ready_after_init", 64'(bpi.ready), 64'd1);
    chk("init_stat_br", 64'(bpi.stat_branches), 64'd0);
    chk("init_stat_mp", 64'(bpi.stat_mispredicts), 64'd0);
    chk("run_target", 64'(bpi.pred_target), 64'h00400014);

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      bpi.pc_if = vt[i].pc;
      set_upd(vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utg,
              vt[i].ept, vt[i].etg);
      #1;
      chk($sformatf("v%0d_hit", i), 64'(bpi.pred_hit),
          64'(vt[i].e_hit));
      chk($sformatf("v%0d_taken", i), 64'(bpi.pred_taken),
          64'(vt[i].e_tk));
      chk($sformatf("v%0d_target", i), 64'(bpi.pred_target),
          64'(vt[i].e_tgt));
      chk($sformatf("v%0d_mp", i), 64'(bpi.mispredict),
          64'(vt[i].e_mp));
      chk($sformatf("v%0d_redirect", i),
          64'(bpi.redirect_pc), 64'(vt[i].e_rd));
      if (i == 1)
        chk("alloc_stat_mp", 64'(bpi.stat_mispredicts), 64'd1);
      tick(0);
    end
    set_upd(0, 0, 0, 0, 0, 0);
    #1;
    chk("table_stat_br", 64'(bpi.stat_branches), 64'd10);
    chk("table_stat_mp", 64'(bpi.stat_mispredicts), 64'd6);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tg;
      bpi.pc_if = 32'h00400000 |
        (32'($urandom_range(0, 15)) << 2) |
        (32'($urandom_range(0, 3)) << 8);
      tg = 32'h00400000 | (32'($urandom_range(0, 63)) << 2);
      set_upd($urandom_range(0, 3) != 0,
              32'h00400000 |
                (32'($urandom_range(0, 15)) << 2) |
                (32'($urandom_range(0, 3)) << 8),
              $urandom_range(0, 1) == 1, tg,
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ?
                (tg ^ 32'h40) : tg);
      tick(1);
    end

    // Reset mid-run: train, pulse reset, count init length.
    bpi.pc_if = 32'h00400020;
    set_upd(1, 32'h00400020, 1, 32'h00400008, 0, 32'h0);
    tick(1);
    set_upd(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("rst_stat_br", 64'(bpi.stat_branches), 64'd0);
    chk("rst_stat_mp", 64'(bpi.stat_mispredicts), 64'd0);
    n = 0;
    while (!bpi.ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("rst_run_init_len", 64'(n), 64'd64);
    #1;
    chk("rst_run_miss", 64'(bpi.pred_hit), 64'd0);
    tick(1);

    // Reset mid-init restarts the sweep at index 0.
    rst = 1'b1;
    tick(1);
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n = 0;
    while (!bpi.ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("rst_init_len", 64'(n), 64'd64);
    for (int i = 0; i < 4; i++) begin
      set_upd(1, 32'h00400080, 1, 32'h00400010, 0, 32'h0);
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined MIPS core. It holds a direct-mapped branch target buffer with saturating direction counters, looked up with the IF-stage PC and trained from the EX-stage branch outcome. It also flags EX-stage mispredicts and supplies the corrected fetch PC. This replaces the fixed "predict not-taken, flush on EX-resolved beq" scheme with taken-path fetch and mispredict statistics.

## Interface
- ADDR_W, 32, PC/target width.
- ENTRIES, 64, number of BTB entries; power of two, ≥4.
- CTR_W, 2, direction counter width, ≥1.
- STAT_W, 32, statistics counter width.
- Clk  in  1  core clock (slow_clk domain); all state updates on its rising edge.
- Reset  in  1  synchronous, active-high.
- ready  out  1  0 during table initialisation, 1 in normal operation.
- pc_if  in  ADDR_W  fetch PC, used for the lookup.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  prediction that the branch is taken.
- pred_target  out  ADDR_W  next fetch PC.
- upd_valid  in  1  a conditional branch is resolved in EX this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- ex_pred_taken  in  1  prediction carried down the pipeline with the branch.
- ex_pred_target  in  ADDR_W  predicted target carried with the branch.
- mispredict  out  1  EX redirect required.
- redirect_pc  out  ADDR_W  corrected fetch PC.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

## Operation
- IDX_W = log2(ENTRIES). The index is pc[IDX_W+1:2]. The tag is pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target[ADDR_W], ctr[CTR_W].
- States are INIT and RUN.
  - Reset forces INIT, sets init_idx=0, and zeroes both stats counters.
  - In INIT, every edge with Reset=0 clears the valid bit of entry init_idx, sets its ctr to 2^(CTR_W-1)-1 (weakly not-taken), and increments init_idx.
  - The clear of entry ENTRIES-1 moves the state to RUN.
- Lookup is combinational in both states.
  - pred_hit = ready & valid & tag match.
  - pred_taken = pred_hit & ctr[CTR_W-1].
  - pred_target = pred_taken ? entry target : pc_if+4, with wrap-around modulo 2^ADDR_W.
- The mispredict output is combinational and gated by ready & upd_valid.
  - mispredict = (upd_taken != ex_pred_taken) | (upd_taken & upd_target != ex_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - Both outputs are driven regardless of mispredict; the consumer qualifies them.
- Updates are applied at the edge, only in RUN with upd_valid=1.
  - Hit, taken: ctr saturating-increments (stays at 2^CTR_W-1), and target is set to upd_target.
  - Hit, not-taken: ctr saturating-decrements (stays at 0), and target is unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. Set valid=1, tag, target, and ctr=2^(CTR_W-1) (weakly taken).
  - Miss, not-taken: no change.
- Statistics, in RUN only:
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each mispredict.
  - Both counters saturate at all-ones.
- In INIT, updates are ignored and not counted.

## Timing
- Reset values: ready=0, pred_hit=0, pred_taken=0, pred_target=pc_if+4, mispredict=0, stats=0.
- Reset sampled high at edge k gives INIT. If Reset is low from edge k+1, ready rises after edge k+ENTRIES and is 1 in cycle k+ENTRIES+1.
- Reset asserted mid-INIT or mid-RUN restarts the sweep at index 0. Holding Reset high keeps init_idx at 0.
- Lookup has zero latency (combinational from pc_if). An update is visible to lookups from the cycle after its edge.
- A same-cycle lookup and update of the same index returns the pre-update entry; there is no bypass.
- mispredict and redirect_pc have zero latency from the EX inputs.

## Structure
- Package bp_pkg holds:
  - the state enum {INIT, RUN};
  - CTR_WEAK_T = 2^(CTR_W-1) and CTR_WEAK_NT = CTR_WEAK_T-1 as functions of CTR_W;
  - the BTB entry typedef.
- Sub-module bp_sat_ctr: a parametrised CTR_W saturating up/down next-value function, instantiated once on the update path.
- Table storage is register arrays; the valid bits are a separate vector.

## Test plan
All scenarios use the default parameters (ENTRIES=64, CTR_W=2).
- Init: pulse Reset for 1 cycle, then set pc_if=0x00400010 → ready=0 for 64 cycles and 1 from cycle 65; pred_hit=0, pred_target=0x00400014.
- Allocate: upd pc=0x00400020, taken, target=0x00400008, ex_pred_taken=0 → mispredict=1, redirect_pc=0x00400008, stat_mispredicts=1. On the next cycle a lookup of 0x00400020 gives hit=1, taken=1, target=0x00400008.
- Saturation: 3 more taken updates, then 2 not-taken → ctr 3→2→1 and pred_taken=0. For the second not-taken update with ex_pred_taken=1: mispredict=1, redirect_pc=0x00400024.
- Alias: after the allocate scenario, a taken update of 0x00400120 (index 8) → a lookup of 0x00400020 misses and a lookup of 0x00400120 hits.
- Same cycle: pc_if=upd_pc=0x00400040 with a first taken update → lookup hit=0 that cycle and hit=1 on the next.
- Reset mid-run: train 0x00400020, then pulse Reset → stats=0, ready=0 for 64 cycles, and a lookup of 0x00400020 misses after ready.
